// File: rtl/rv16_ctrl_pkg.sv
// Shared encodings for the RISC-16 control unit: state codes, opcode map and opcode classifier.
// Pure declarations: no latency and no flow control of its own.
package rv16_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_ALU,
        CL_IMM,
        CL_LOAD,
        CL_STORE,
        CL_BR,
        CL_JMP,
        CL_HALT,
        CL_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic branch;
        logic alu_src;
        logic load;
        logic jump;
    } ctrl_t;

    localparam logic [31:0] OPC_NOP    = 32'd0;
    localparam logic [31:0] OPC_ALU_LO = 32'd1;
    localparam logic [31:0] OPC_ALU_HI = 32'd7;
    localparam logic [31:0] OPC_ADDI   = 32'd8;
    localparam logic [31:0] OPC_LOAD   = 32'd9;
    localparam logic [31:0] OPC_STORE  = 32'd10;
    localparam logic [31:0] OPC_BEQ    = 32'd11;
    localparam logic [31:0] OPC_JUMP   = 32'd12;
    localparam logic [31:0] OPC_HALT   = 32'd15;

    // Opcodes arrive zero-extended so one classifier serves every OPCODE_W.
    function automatic op_class_e classify(input logic [31:0] op);
        op_class_e c;
        case (op)
            OPC_NOP:   c = CL_NOP;
            OPC_ADDI:  c = CL_IMM;
            OPC_LOAD:  c = CL_LOAD;
            OPC_STORE: c = CL_STORE;
            OPC_BEQ:   c = CL_BR;
            OPC_JUMP:  c = CL_JMP;
            OPC_HALT:  c = CL_HALT;
            default:   c = (op >= OPC_ALU_LO && op <= OPC_ALU_HI) ? CL_ALU : CL_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic ctrl_t ctrl_of(input op_class_e c);
        ctrl_t k;
        k         = '0;
        k.branch  = (c == CL_BR);
        k.alu_src = (c == CL_IMM);
        k.load    = (c == CL_LOAD);
        k.jump    = (c == CL_JMP);
        return k;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle between the control unit and decoder/datapath/data memory.
// Wires only: no latency; mem_ready is the sole backpressure input.
interface multicycle_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int PERF_W   = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                branch;
    logic                ALU_src;
    logic                load;
    logic                jump;
    logic                mem_write;
    logic                reg_write;
    logic                PC_enable;
    logic                IR_enable;
    logic                reg_enable;
    logic                mem_enable;
    logic [2:0]          state;
    logic                halted;
    logic                illegal;
    logic                timeout_err;
    logic [PERF_W-1:0]   retired_count;

    modport master (
        input  opcode, mem_ready,
        output branch, ALU_src, load, jump, mem_write, reg_write,
               PC_enable, IR_enable, reg_enable, mem_enable,
               state, halted, illegal, timeout_err, retired_count
    );

    modport slave (
        output opcode, mem_ready,
        input  branch, ALU_src, load, jump, mem_write, reg_write,
               PC_enable, IR_enable, reg_enable, mem_enable,
               state, halted, illegal, timeout_err, retired_count
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles without mem_ready; expired flags the last permitted cycle.
// Latency: count visible the cycle after the strobe; no backpressure.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Counter holds (MEM cycles - 1), so this is the MEM_TIMEOUT-th cycle.
    assign expired = (cnt_q == CW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control unit for the 16-bit RISC core: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
// Latency: 3-5 cycles per instruction plus memory waits; stalls in MEM on mem_ready, bounded by MEM_TIMEOUT.
module multicycle_sequencer
    import rv16_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 16
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_sequencer_if.master bus
);
    state_e              state_q;
    state_e              state_d;
    op_class_e           cls_q;
    op_class_e           dec_cls;
    ctrl_t               ctrl_q;
    logic                illegal_q;
    logic                timeout_q;
    logic [PERF_W-1:0]   retired_q;
    logic [OPCODE_W-1:0] opc;
    logic                pc_en;
    logic                timer_clr;
    logic                timer_cnt;
    logic                timer_exp;
    logic                tmo_set;

    assign opc     = bus.opcode;
    assign dec_cls = classify(32'(opc));

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .count   (timer_cnt),
        .expired (timer_exp)
    );

    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b0;
        timer_clr = 1'b0;
        timer_cnt = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (dec_cls == CL_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (cls_q)
                    CL_ALU, CL_IMM: state_d = ST_WB;
                    CL_LOAD, CL_STORE: begin
                        state_d   = ST_MEM;
                        timer_clr = 1'b1;
                    end
                    default: begin
                        state_d = ST_FETCH;
                        pc_en   = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // A ready in the final permitted cycle beats the timeout.
                if (bus.mem_ready) begin
                    if (cls_q == CL_STORE) begin
                        state_d = ST_FETCH;
                        pc_en   = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timer_exp) begin
                    state_d = ST_ERROR;
                    tmo_set = 1'b1;
                end else begin
                    timer_cnt = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_en   = 1'b1;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CL_NOP;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q  <= dec_cls;
                ctrl_q <= ctrl_of(dec_cls);
                if (dec_cls == CL_ILLEGAL) begin
                    illegal_q <= 1'b1;
                end
            end else if (state_d == ST_FETCH || state_d == ST_ERROR) begin
                ctrl_q <= '0;
            end
            if (tmo_set) begin
                timeout_q <= 1'b1;
            end
            if (pc_en) begin
                retired_q <= retired_q + PERF_W'(1);
            end
        end
    end

    assign bus.state         = state_q;
    assign bus.IR_enable     = (state_q == ST_FETCH);
    assign bus.PC_enable     = pc_en;
    assign bus.reg_enable    = (state_q == ST_WB);
    assign bus.reg_write     = (state_q == ST_WB);
    assign bus.mem_enable    = (state_q == ST_MEM);
    assign bus.mem_write     = (state_q == ST_MEM) && (cls_q == CL_STORE);
    assign bus.branch        = ctrl_q.branch;
    assign bus.ALU_src       = ctrl_q.alu_src;
    assign bus.load          = ctrl_q.load;
    assign bus.jump          = ctrl_q.jump;
    assign bus.halted        = (state_q == ST_HALT);
    assign bus.illegal       = illegal_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Cycle-level bench: a transaction model expands each instruction into its expected per-cycle outputs.
module tb_multicycle_sequencer;
    localparam int OPW = 5;
    localparam int MT  = 4;
    localparam int PW  = 2;

    localparam int K_NOP = 0, K_ALU = 1, K_IMM = 2, K_LOAD = 3, K_STORE = 4;
    localparam int K_BR = 5, K_JMP = 6, K_HALT = 7, K_ILL = 8;

    typedef struct packed {
        logic [2:0]    st;
        logic          ir;
        logic          pc;
        logic          re;
        logic          rw;
        logic          me;
        logic          mw;
        logic          br;
        logic          asrc;
        logic          ld;
        logic          jp;
        logic          hlt;
        logic          ill;
        logic          tmo;
        logic [PW-1:0] ret;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   m_ret;
    logic m_ill;
    logic m_tmo;

    obs_t           exp_q[$];
    obs_t           got_q[$];
    logic [OPW-1:0] opc_q[$];
    logic           rdy_q[$];

    multicycle_sequencer_if #(.OPCODE_W(OPW), .PERF_W(PW)) bus ();

    multicycle_sequencer #(
        .OPCODE_W    (OPW),
        .MEM_TIMEOUT (MT),
        .PERF_W      (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int cls_of(input int op);
        if (op == 0) return K_NOP;
        if (op >= 1 && op <= 7) return K_ALU;
        case (op)
            8:  return K_IMM;
            9:  return K_LOAD;
            10: return K_STORE;
            11: return K_BR;
            12: return K_JMP;
            15: return K_HALT;
            default: return K_ILL;
        endcase
    endfunction

    function automatic obs_t base(input int st);
        obs_t e;
        e     = '0;
        e.st  = 3'(st);
        e.ill = m_ill;
        e.tmo = m_tmo;
        e.ret = PW'(m_ret);
        return e;
    endfunction

    function automatic obs_t ctl(input obs_t e, input int c);
        obs_t r;
        r      = e;
        r.br   = (c == K_BR);
        r.asrc = (c == K_IMM);
        r.ld   = (c == K_LOAD);
        r.jp   = (c == K_JMP);
        return r;
    endfunction

    function automatic int rnd_op();
        return int'($urandom_range(0, (1 << OPW) - 1));
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input obs_t e, input int op, input logic r);
        exp_q.push_back(e);
        opc_q.push_back(OPW'(op));
        rdy_q.push_back(r);
        if (e.pc) m_ret = (m_ret + 1) % (1 << PW);
    endtask

    // Expected trace of one instruction; rd = MEM cycle carrying mem_ready (0 = never).
    task automatic model_instr(input int op, input int rd, input int tail);
        int   c;
        obs_t e;
        c = cls_of(op);
        e = base(0);
        e.ir = 1'b1;
        push(e, rnd_op(), rnd_bit());
        push(base(1), op, rnd_bit());
        if (c == K_HALT) begin
            for (int i = 0; i < tail; i++) begin
                e = base(5);
                e.hlt = 1'b1;
                push(e, rnd_op(), rnd_bit());
            end
            return;
        end
        if (c == K_ILL) m_ill = 1'b1;
        e = ctl(base(2), c);
        e.pc = (c inside {K_NOP, K_BR, K_JMP, K_ILL});
        push(e, rnd_op(), rnd_bit());
        if (e.pc) return;
        if (c == K_ALU || c == K_IMM) begin
            e = ctl(base(4), c);
            e.re = 1'b1; e.rw = 1'b1; e.pc = 1'b1;
            push(e, rnd_op(), rnd_bit());
            return;
        end
        for (int k = 1; k <= MT; k++) begin
            e = ctl(base(3), c);
            e.me = 1'b1;
            e.mw = (c == K_STORE);
            if (k == rd) begin
                e.pc = (c == K_STORE);
                push(e, rnd_op(), 1'b1);
                if (c == K_LOAD) begin
                    e = ctl(base(4), c);
                    e.re = 1'b1; e.rw = 1'b1; e.pc = 1'b1;
                    push(e, rnd_op(), rnd_bit());
                end
                return;
            end
            push(e, rnd_op(), 1'b0);
        end
        m_tmo = 1'b1;
        for (int i = 0; i < tail; i++) push(base(6), rnd_op(), rnd_bit());
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st   = bus.state;
        o.ir   = bus.IR_enable;
        o.pc   = bus.PC_enable;
        o.re   = bus.reg_enable;
        o.rw   = bus.reg_write;
        o.me   = bus.mem_enable;
        o.mw   = bus.mem_write;
        o.br   = bus.branch;
        o.asrc = bus.ALU_src;
        o.ld   = bus.load;
        o.jp   = bus.jump;
        o.hlt  = bus.halted;
        o.ill  = bus.illegal;
        o.tmo  = bus.timeout_err;
        o.ret  = bus.retired_count;
        return o;
    endfunction

    // Called at a negedge aligned with the trace's first FETCH cycle.
    task automatic capture(input int n);
        got_q.delete();
        for (int i = 0; i < n; i++) begin
            bus.opcode    = opc_q[i];
            bus.mem_ready = rdy_q[i];
            #1;
            got_q.push_back(sample());
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ret = 0;
        m_ill = 1'b0;
        m_tmo = 1'b0;
        exp_q.delete(); opc_q.delete(); rdy_q.delete(); got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        checks++;
        if ({bus.branch, bus.ALU_src, bus.load, bus.jump, bus.mem_write, bus.reg_write,
             bus.PC_enable, bus.reg_enable, bus.mem_enable, bus.halted} !== 10'b0) begin
            errors++; $display("FAIL reset_controls: some control/enable nonzero during reset");
        end
        checks++;
        if ({bus.illegal, bus.timeout_err} !== 2'b00 || bus.retired_count !== PW'(0)) begin
            errors++; $display("FAIL reset_flags: illegal=%b timeout_err=%b retired=%0d expected all 0",
                               bus.illegal, bus.timeout_err, bus.retired_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.IR_enable !== 1'b1 || bus.state !== 3'd0) begin
            errors++; $display("FAIL reset_release: IR_enable=%b state=%0d expected 1/0", bus.IR_enable, bus.state);
        end
    endtask

    task automatic test_alu();
        do_reset();
        model_instr(int'($urandom_range(1, 8)), 0, 0);
        capture(exp_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL alu cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        #1;
        checks++;
        if (bus.retired_count !== PW'(1) || bus.state !== 3'd0) begin
            errors++; $display("FAIL alu_retire: retired=%0d state=%0d expected 1/0", bus.retired_count, bus.state);
        end
    endtask

    task automatic test_load();
        int nxt;
        do_reset();
        model_instr(9, 3, 0);
        model_instr(9, int'($urandom_range(1, MT)), 0);
        model_instr(9, MT, 0);
        capture(exp_q.size());
        nxt = -1;
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL load cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            checks++;
            if (got_q[i].mw !== 1'b0) begin
                errors++; $display("FAIL load_no_write cycle %0d: mem_write=%b expected 0", i, got_q[i].mw);
            end
            if (i > 0 && nxt < 0 && got_q[i].st == 3'd0) nxt = i;
        end
        checks++;
        if (nxt !== 7) begin
            errors++; $display("FAIL load_latency: got %0d cycles expected 7", nxt);
        end
    endtask

    task automatic test_store_timeout();
        int npc, nmw;
        do_reset();
        model_instr(10, 0, 5);
        capture(exp_q.size());
        npc = 0;
        nmw = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL store_timeout cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            npc += int'(got_q[i].pc);
            nmw += int'(got_q[i].mw);
        end
        checks++;
        if (npc !== 0 || nmw !== MT) begin
            errors++; $display("FAIL store_timeout_counts: PC_enable cycles=%0d mem_write cycles=%0d expected 0/%0d", npc, nmw, MT);
        end
        #1;
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.state !== 3'd6 || bus.retired_count !== PW'(0)) begin
            errors++; $display("FAIL store_timeout_end: timeout_err=%b state=%0d retired=%0d expected 1/6/0",
                               bus.timeout_err, bus.state, bus.retired_count);
        end
        do_reset();
        #1;
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: timeout_err=%b expected 0", bus.timeout_err);
        end
    endtask

    task automatic test_branch_jump_illegal();
        do_reset();
        model_instr(11, 0, 0);
        model_instr(12, 0, 0);
        model_instr(13, 0, 0);
        capture(exp_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL br_jmp_ill cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q[2].br !== 1'b1 || got_q[5].jp !== 1'b1 || got_q[7].ill !== 1'b0 || got_q[8].ill !== 1'b1) begin
            errors++; $display("FAIL br_jmp_ill_flags: branch=%b jump=%b illegal@dec=%b illegal@exec=%b expected 1/1/0/1",
                               got_q[2].br, got_q[5].jp, got_q[7].ill, got_q[8].ill);
        end
        #1;
        checks++;
        if (bus.retired_count !== PW'(3)) begin
            errors++; $display("FAIL br_jmp_ill_retire: retired=%0d expected 3", bus.retired_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        model_instr(15, 0, 20);
        capture(exp_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL halt cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.IR_enable !== 1'b1 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_exit: state=%0d IR_enable=%b halted=%b expected 0/1/0",
                               bus.state, bus.IR_enable, bus.halted);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 5; n++) model_instr(0, 0, 0);
        capture(exp_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        #1;
        checks++;
        if (bus.retired_count !== PW'(1)) begin
            errors++; $display("FAIL wrap_final: retired=%0d expected 1", bus.retired_count);
        end
    endtask

    task automatic test_back_to_back();
        int op;
        do_reset();
        for (int n = 0; n < 25; n++) begin
            op = rnd_op();
            if (op == 15) op = 0;
            model_instr(op, int'($urandom_range(1, MT)), 0);
        end
        capture(exp_q.size());
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL back_to_back cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        do_reset();
        model_instr(13, 0, 0);
        model_instr(int'($urandom_range(1, 7)), 0, 0);
        model_instr(9, 0, 0);
        n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (n == 0 && exp_q[i].st == 3'd3) n = i + 1;
        end
        capture(n);
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL mid_mem cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_enable !== 1'b1 || bus.state !== 3'd3) begin
            errors++; $display("FAIL mid_mem_sync: mem_enable=%b state=%0d expected 1/3 before the edge",
                               bus.mem_enable, bus.state);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.mem_enable !== 1'b0 || bus.load !== 1'b0 ||
            bus.illegal !== 1'b0 || bus.retired_count !== PW'(0)) begin
            errors++; $display("FAIL mid_mem_reset: state=%0d mem_enable=%b load=%b illegal=%b retired=%0d expected 0/0/0/0/0",
                               bus.state, bus.mem_enable, bus.load, bus.illegal, bus.retired_count);
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store_timeout();
        test_branch_jump_illegal();
        test_halt();
        test_wrap();
        test_back_to_back();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised next-generation multicycle control unit for the 16-bit RISC core.
- Replaces the fixed control FSM. Drives the per-phase enables (PC, IR, register file, data memory) and the datapath controls.
- Adds memory wait-state handshake with timeout, HALT and illegal-opcode handling, and a retired-instruction counter.
- Sits between the instruction decoder (opcode source) and the program counter, register file, ALU and data memory.

Parameters:
- OPCODE_W, 4, opcode width; must be ≥4. Any value ≥16 is illegal.
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for mem_ready; must be ≥1.
- PERF_W, 16, width of retired_count.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  OPCODE_W  from instruction decoder; sampled only in DECODE
- mem_ready  in  1  data memory completion; ignored outside MEM
- branch, ALU_src, load, jump  out  1 each  datapath controls, registered
- mem_write  out  1  store strobe
- reg_write  out  1  register write
- PC_enable, IR_enable, reg_enable, mem_enable  out  1 each  phase enables
- state  out  3  current state encoding, for debug
- halted  out  1  high in HALT
- illegal  out  1  sticky illegal-opcode flag
- timeout_err  out  1  sticky memory-timeout flag
- retired_count  out  PERF_W  instructions retired

Behaviour:
- Reset: rst has priority and is synchronous.
  - Next state is FETCH. All controls are 0; counters and flags are 0.
  - In the first cycle after rst falls, IR_enable=1.
- Opcode map:
  - 0 NOP
  - 1–7 ALU reg-reg
  - 8 ADDI (ALU_src=1)
  - 9 LOAD (load=1)
  - 10 STORE
  - 11 BEQ (branch=1)
  - 12 JUMP (jump=1)
  - 15 HALT
  - 13, 14 and ≥16 are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- FETCH: IR_enable=1. Next state DECODE.
- DECODE:
  - Latches branch, ALU_src, load, jump from opcode. These hold until the instruction's final state and are cleared on entry to FETCH.
  - HALT opcode → HALT.
  - Illegal opcode → set illegal, treat as NOP (go to EXEC).
  - Otherwise → EXEC.
- EXEC:
  - ALU/ADDI → WB.
  - LOAD/STORE → MEM, with the wait counter cleared.
  - NOP/BEQ/JUMP/illegal: PC_enable=1 this cycle, then → FETCH.
- MEM:
  - mem_enable=1 every cycle. mem_write=1 every cycle only for STORE.
  - On mem_ready: STORE asserts PC_enable this cycle and goes → FETCH; LOAD goes → WB.
  - Without ready, the wait counter increments. If MEM_TIMEOUT cycles elapse in MEM with no ready → ERROR, with timeout_err=1.
  - mem_ready in the last allowed cycle wins over timeout.
- WB: reg_enable=1, reg_write=1, PC_enable=1. Next state FETCH.
- HALT: halted=1, all enables and controls 0. Stays until rst.
- ERROR: all enables and controls 0, timeout_err=1. Stays until rst.
- Enables are Moore outputs decoded from the registered state. PC_enable is asserted exactly one cycle per retired instruction.
- Latency in cycles, FETCH through final state:
  - NOP/BEQ/JUMP: 3
  - ALU/ADDI: 4
  - STORE: 4 + wait cycles
  - LOAD: 5 + wait cycles
  - where wait cycles = MEM cycles − 1.
- retired_count increments on every PC_enable cycle and wraps modulo 2^PERF_W.
- illegal and timeout_err clear only on rst.
- Reset mid-MEM: the wait counter clears and mem_enable drops in the cycle after the rst edge.

Decomposition:
- Package rv16_ctrl_pkg holds:
  - the state encoding constants
  - the opcode constants
  - a helper function that classifies an opcode into NOP/ALU/IMM/LOAD/STORE/BR/JMP/HALT/ILLEGAL.
- Sub-module mem_wait_timer: clear/count/expired counter sized $clog2(MEM_TIMEOUT+1).

Test Plan:
- Reset, then opcode=1 with mem_ready tied 0 → states 0,1,2,4. reg_write and PC_enable high only in cycle 4. retired_count=1.
- LOAD (9), mem_ready raised on the 3rd MEM cycle → 7 cycles total. load=1 from EXEC through WB. mem_write never high.
- STORE (10), mem_ready held low, MEM_TIMEOUT=4 → 4 MEM cycles with mem_write=1, then ERROR. timeout_err=1, PC_enable stays 0, retired_count unchanged.
- Sequence BEQ, JUMP, 13 → each takes 3 cycles. branch and jump are set in their respective EXEC cycles. illegal=1 after the 3rd instruction's DECODE. retired_count=3.
- HALT (15) → halted=1 after DECODE, all enables 0 for 20 cycles. rst pulse → state=0, IR_enable=1, halted=0.
- PERF_W=2, five NOPs → retired_count sequence 1,2,3,0,1. Also assert rst during a LOAD's MEM state → next state FETCH and all flags clear.
